// File: rtl/dvp_capture_if.sv
// Sensor-side DVP byte bus and the downstream vs/de/data video stream.
// The master modport is the capture block; the slave modport is its environment.
interface dvp_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        post_vs;
  logic        post_de;
  logic [15:0] post_data;

  modport master (
    input  cam_vsync, cam_href, cam_data,
    output post_vs, post_de, post_data
  );

  modport slave (
    output cam_vsync, cam_href, cam_data,
    input  post_vs, post_de, post_data
  );
endinterface

// File: rtl/dvp_capture.sv
// DVP camera capture: drops the settling frames after reset, then pairs
// RGB565 bytes (high first) into pixels and checks line and frame geometry.
module dvp_capture #(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EN,
  dvp_capture_if.master        vid,
  output logic [7:0]           frame_cnt,
  output logic                 size_err,
  output logic                 odd_err
);

  localparam int SKW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SKW-1:0] SKIP_LIM = SKW'(SKIP_FRAMES);
  localparam logic [11:0]    H_LIM    = 12'(H_DISP);
  localparam logic [11:0]    V_LIM    = 12'(V_DISP);
  localparam logic [11:0]    CNT_MAX  = 12'hFFF;

  localparam logic [1:0] ST_SKIP   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic           vs1_r, hr1_r, vs2_r, hr2_r;
  logic [7:0]     d1_r;
  logic [1:0]     state_r, state_nx_s;
  logic [SKW-1:0] skip_cnt_r;
  logic           phase_r;
  logic [7:0]     hi_r;
  logic [11:0]    pix_cnt_r, line_cnt_r;
  logic           post_vs_r, post_de_r;
  logic [15:0]    post_data_r;
  logic [7:0]     frame_cnt_r;
  logic           size_err_r, odd_err_r;

  logic frame_start_s, frame_end_s, href_ok_s, line_end_s, active_s, capture_go_s;

  // Stage-1 input registers and their delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      vs1_r <= 1'b0;
      hr1_r <= 1'b0;
      d1_r  <= 8'd0;
      vs2_r <= 1'b0;
      hr2_r <= 1'b0;
    end else begin
      vs1_r <= vid.cam_vsync;
      hr1_r <= vid.cam_href;
      d1_r  <= vid.cam_data;
      vs2_r <= vs1_r;
      hr2_r <= hr1_r;
    end
  end

  // Frame/line events; href is ignored while vsync marks blanking
  always_comb begin
    frame_start_s = vs2_r & ~vs1_r;
    frame_end_s   = ~vs2_r & vs1_r;
    href_ok_s     = hr1_r & ~vs1_r;
    line_end_s    = hr2_r & ~hr1_r & ~vs1_r;
    active_s      = (state_r == ST_ACTIVE);
    capture_go_s  = (state_r == ST_IDLE) & frame_start_s & EN;
  end

  // Next-state logic for the skip/idle/active sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_SKIP: begin
        if (skip_cnt_r >= SKIP_LIM) state_nx_s = ST_IDLE;
        else                        state_nx_s = ST_SKIP;
      end
      ST_IDLE: begin
        if (capture_go_s) state_nx_s = ST_ACTIVE;
        else              state_nx_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (frame_end_s) state_nx_s = ST_IDLE;
        else             state_nx_s = ST_ACTIVE;
      end
      default: state_nx_s = ST_SKIP;
    endcase
  end

  // State register and settling-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_SKIP;
      skip_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if ((state_r == ST_SKIP) && frame_end_s && (skip_cnt_r < SKIP_LIM))
        skip_cnt_r <= skip_cnt_r + SKW'(1);
    end
  end

  // Byte pairing, geometry counters, status and registered video outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r     <= 1'b0;
      hi_r        <= 8'd0;
      pix_cnt_r   <= 12'd0;
      line_cnt_r  <= 12'd0;
      post_vs_r   <= 1'b0;
      post_de_r   <= 1'b0;
      post_data_r <= 16'd0;
      frame_cnt_r <= 8'd0;
      size_err_r  <= 1'b0;
      odd_err_r   <= 1'b0;
    end else begin
      post_de_r <= 1'b0;
      post_vs_r <= (state_r == ST_SKIP) ? 1'b0 : vs1_r;
      if (capture_go_s) begin
        phase_r    <= 1'b0;
        pix_cnt_r  <= 12'd0;
        line_cnt_r <= 12'd0;
      end else if (active_s) begin
        if (frame_end_s) begin
          frame_cnt_r <= frame_cnt_r + 8'd1;
          if (line_cnt_r != V_LIM) size_err_r <= 1'b1;
        end else if (href_ok_s) begin
          if (!phase_r) begin
            hi_r    <= d1_r;
            phase_r <= 1'b1;
          end else begin
            post_data_r <= {hi_r, d1_r};
            post_de_r   <= 1'b1;
            phase_r     <= 1'b0;
            if (pix_cnt_r != CNT_MAX) pix_cnt_r <= pix_cnt_r + 12'd1;
          end
        end else if (line_end_s) begin
          // An unpaired trailing byte is discarded, never merged into the next line
          if (phase_r) begin
            odd_err_r <= 1'b1;
            phase_r   <= 1'b0;
          end
          if (pix_cnt_r != H_LIM) size_err_r <= 1'b1;
          if (line_cnt_r != CNT_MAX) line_cnt_r <= line_cnt_r + 12'd1;
          pix_cnt_r <= 12'd0;
        end
      end
    end
  end

  assign vid.post_vs   = post_vs_r;
  assign vid.post_de   = post_de_r;
  assign vid.post_data = post_data_r;
  assign frame_cnt     = frame_cnt_r;
  assign size_err      = size_err_r;
  assign odd_err       = odd_err_r;

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture with a 4x2 frame geometry and two settling frames.
module tb_dvp_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       EN;
  logic [7:0] frame_cnt;
  logic       size_err, odd_err;

  dvp_capture_if vif();

  dvp_capture #(.H_DISP(H), .V_DISP(V), .SKIP_FRAMES(SK)) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .vid       (vif),
    .frame_cnt (frame_cnt),
    .size_err  (size_err),
    .odd_err   (odd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       chk_vs_low = 1'b0;
  logic       vs_seen = 1'b0;
  logic [7:0] pat [0:7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every post_de strobe
  always @(negedge clk) begin
    if (vif.post_vs === 1'b1) vs_seen = 1'b1;
    if (chk_vs_low) chk("post_vs_low_in_skip", {31'd0, vif.post_vs}, 32'd0);
    if (vif.post_de !== 1'b0) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_de: got post_de=%b data=0x%h, expected no pixel (cycle %0d)",
                 vif.post_de, vif.post_data, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("pixel_data", {16'd0, vif.post_data}, {16'd0, mon_e.d});
        chk("pixel_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) pat[i] = base + 8'(i * 17);
  endtask

  task automatic send_line(input int n, input bit cap);
    exp_t e;
    logic [7:0] prev;
    prev = 8'd0;
    for (int i = 0; i < n; i++) begin
      tick();
      vif.cam_href = 1'b1;
      vif.cam_data = pat[i];
      if (cap && (i % 2 == 1)) begin
        e.d = {prev, pat[i]};
        e.c = cyc + 2;
        q.push_back(e);
      end
      prev = pat[i];
    end
    tick();
    vif.cam_href = 1'b0;
    vif.cam_data = 8'd0;
    repeat (3) tick();
  endtask

  task automatic vpulse(input logic en_next);
    tick();
    vif.cam_vsync = 1'b1;
    EN = en_next;
    repeat (3) tick();
    tick();
    vif.cam_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame(input int nl, input int nb, input bit cap, input logic en_next);
    for (int l = 0; l < nl; l++) send_line(nb, cap);
    vpulse(en_next);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    EN  = 1'b1;
    vif.cam_vsync = 1'b0;
    vif.cam_href  = 1'b0;
    vif.cam_data  = 8'd0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_post_de",    {31'd0, vif.post_de}, 32'd0);
    chk("rst_post_data",  {16'd0, vif.post_data}, 32'd0);
    chk("rst_post_vs",    {31'd0, vif.post_vs}, 32'd0);
    chk("rst_frame_cnt",  {24'd0, frame_cnt}, 32'd0);
    chk("rst_size_err",   {31'd0, size_err}, 32'd0);
    chk("rst_odd_err",    {31'd0, odd_err}, 32'd0);
    tick();
    rst = 1'b0;

    // Two settling frames produce nothing and keep post_vs low
    fill(8'h10);
    chk_vs_low = 1'b1;
    frame(V, 2 * H, 1'b0, 1'b1);
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    chk_vs_low = 1'b0;
    vpulse(1'b1);

    // Third frame is captured; first pixels F81F then 07E0
    vs_seen = 1'b0;
    pat[0] = 8'hF8; pat[1] = 8'h1F; pat[2] = 8'h07; pat[3] = 8'hE0;
    pat[4] = 8'h12; pat[5] = 8'h34; pat[6] = 8'hAB; pat[7] = 8'hCD;
    send_line(2 * H, 1'b1);
    fill(8'h40);
    send_line(2 * H, 1'b1);
    vpulse(1'b0);
    @(negedge clk);
    chk("f3_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("f3_size_err",  {31'd0, size_err}, 32'd0);
    chk("f3_odd_err",   {31'd0, odd_err}, 32'd0);
    chk("f3_post_vs_seen", {31'd0, vs_seen}, 32'd1);
    chk("f3_queue_drained", q.size(), 32'd0);

    // EN low at frame start: the frame is skipped even if EN rises mid-frame
    send_line(2 * H, 1'b0);
    EN = 1'b1;
    send_line(2 * H, 1'b0);
    vpulse(1'b1);
    @(negedge clk);
    chk("en0_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    fill(8'h80);
    frame(V, 2 * H, 1'b1, 1'b1);
    @(negedge clk);
    chk("en1_frame_cnt", {24'd0, frame_cnt}, 32'd2);

    // 254 more captured frames wrap frame_cnt from 255 to 0
    for (int k = 0; k < 254; k++) begin
      fill(8'(k));
      frame(V, 2 * H, 1'b1, 1'b1);
    end
    @(negedge clk);
    chk("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("wrap_size_err",  {31'd0, size_err}, 32'd0);
    chk("wrap_queue_drained", q.size(), 32'd0);

    // Three lines against V_DISP=2 flags a height error
    fill(8'h21);
    frame(3, 2 * H, 1'b1, 1'b1);
    @(negedge clk);
    chk("tall_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("tall_size_err",  {31'd0, size_err}, 32'd1);
    chk("tall_odd_err",   {31'd0, odd_err}, 32'd0);

    // Reset in the middle of a captured line
    tick();
    vif.cam_href = 1'b1;
    vif.cam_data = 8'hAA;
    tick();
    rst = 1'b1;
    vif.cam_href = 1'b0;
    vif.cam_data = 8'd0;
    tick();
    @(negedge clk);
    chk("mid_rst_post_de",   {31'd0, vif.post_de}, 32'd0);
    chk("mid_rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("mid_rst_size_err",  {31'd0, size_err}, 32'd0);
    chk("mid_rst_odd_err",   {31'd0, odd_err}, 32'd0);
    chk("mid_rst_post_vs",   {31'd0, vif.post_vs}, 32'd0);
    tick();
    rst = 1'b0;

    // Settling repeats, then a 7-byte line gives 3 pixels and both errors
    fill(8'h55);
    chk_vs_low = 1'b1;
    frame(V, 2 * H, 1'b0, 1'b1);
    send_line(2 * H, 1'b0);
    send_line(2 * H, 1'b0);
    chk_vs_low = 1'b0;
    vpulse(1'b1);
    fill(8'h61);
    send_line(7, 1'b1);
    @(negedge clk);
    chk("odd_line_odd_err",  {31'd0, odd_err}, 32'd1);
    chk("odd_line_size_err", {31'd0, size_err}, 32'd1);
    chk("odd_line_queue",    q.size(), 32'd0);
    fill(8'h90);
    send_line(2 * H, 1'b1);
    @(negedge clk);
    chk("next_line_odd_err",  {31'd0, odd_err}, 32'd1);
    chk("next_line_size_err", {31'd0, size_err}, 32'd1);
    vpulse(1'b1);
    @(negedge clk);
    chk("post_rst_frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("final_queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
